// File: rtl/uart_pkg.sv
// Shared types and helpers for the MMIO UART transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit so full and empty
// are told apart without a separate count.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [AW:0] wr_q, rd_q;
  logic [7:0]  mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Push into a full FIFO only happens alongside a pop: the slot being
  // overwritten is the head, which dout has already presented this cycle.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO UART transmitter: FIFO-buffered 8N1 serialiser, 8E1 when
// UART_TX_PARITY_EN is defined.
module uart_mmio_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        mmio_wea,
  input  logic [31:0] mmio_dat,
  output logic        mmio_read,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_IRQ,
  output logic        tx_ovf
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = (CPB < 2) ? 1 : $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  if (CPB < 2) begin : g_bad_baud
    $error("uart_mmio_tx: CLK_FREQ/BAUD must be at least 2");
  end

  tx_state_t                 state_q;
  logic [CW-1:0]             cnt_q;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] sh_q;
  logic                      tx_q, ovf_q;
`ifdef UART_TX_PARITY_EN
  logic                      par_q;
`endif

  logic       fifo_full, fifo_empty, bit_end, pop, push;
  logic [7:0] fifo_dout;
  logic       unused_dat;

  assign unused_dat = ^mmio_dat[31:8];
  assign bit_end    = (cnt_q == CNT_LAST);
  // Pop from IDLE, or straight out of STOP so consecutive frames abut.
  assign pop  = !fifo_empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign push = mmio_wea && (!fifo_full || pop);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (Rst_n),
    .push  (push),
    .pop   (pop),
    .din   (mmio_dat[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ovf_q <= mmio_wea && fifo_full && !pop;
      cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      if (pop) begin
        sh_q    <= fifo_dout;
        tx_q    <= 1'b0;
        state_q <= START;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^fifo_dout;
`endif
      end else begin
        case (state_q)
          START: if (bit_end) begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= sh_q[0];
          end
          DATA: if (bit_end) begin
            if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
              idx_q <= idx_q + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
`endif
          STOP: if (bit_end) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx        = tx_q;
  assign tx_ovf    = ovf_q;
  assign tx_busy   = (state_q != IDLE);
  assign tx_IRQ    = fifo_empty && (state_q == IDLE);
  assign mmio_read = !fifo_full;

endmodule
